// File: rtl/data_ram_resp_pkg.sv
// Shared bus widths, FSM state encoding and counter sizing for the data RAM
// responder and its storage array.
package data_ram_resp_pkg;

    localparam int DataBus     = 32;
    localparam int DataAddrBus = 32;
    localparam int ByteWidth   = 8;
    localparam int SelW        = DataBus / ByteWidth;
    localparam int CntW        = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/data_ram_array.sv
// Word storage built from four byte lanes with per-lane write enables and a
// registered (synchronous) read port; only the read register is reset.
module data_ram_array
    import data_ram_resp_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SelW-1:0]     we,
    input  logic                re,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DataBus-1:0]  wdata,
    output logic [DataBus-1:0]  rdata
);

    localparam int Depth = 1 << ADDR_W;

    for (genvar l = 0; l < SelW; l++) begin : g_lane
        logic [ByteWidth-1:0] mem [Depth];
        logic [ByteWidth-1:0] q;

        always_ff @(posedge clk) begin
            if (we[l]) begin
                mem[addr] <= wdata[l*ByteWidth +: ByteWidth];
            end
        end

        // Read register holds its value between reads, so it doubles as mem_data_o.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                q <= '0;
            end else if (re) begin
                q <= mem[addr];
            end
        end

        assign rdata[l*ByteWidth +: ByteWidth] = q;
    end

endmodule

// File: rtl/data_ram_resp.sv
// Multi-cycle data RAM responder for the CPU MEM stage: captures a request,
// inserts WAIT_STATES wait cycles, then performs the access and pulses ready.
module data_ram_resp
    import data_ram_resp_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_ce_i,
    input  logic                   mem_we_i,
    input  logic [DataAddrBus-1:0] mem_addr_i,
    input  logic [SelW-1:0]        mem_sel_i,
    input  logic [DataBus-1:0]     mem_data_i,
    output logic [DataBus-1:0]     mem_data_o,
    output logic                   stallreq_o,
    output logic                   ready_o
);

    state_t             state, next_state;
    logic [CntW-1:0]    cnt;
    logic [ADDR_W-1:0]  cap_addr;
    logic               cap_we;
    logic [SelW-1:0]    cap_sel;
    logic [DataBus-1:0] cap_data;
    logic               fire;
    logic [SelW-1:0]    lane_we;
    logic               re;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^{mem_addr_i[DataAddrBus-1:ADDR_W+2], mem_addr_i[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cap_addr <= '0;
            cap_we   <= 1'b0;
            cap_sel  <= '0;
            cap_data <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && mem_ce_i) begin
                cap_addr <= mem_addr_i[ADDR_W+1:2];
                cap_we   <= mem_we_i;
                cap_sel  <= mem_sel_i;
                cap_data <= mem_data_i;
                cnt      <= CntW'(WAIT_STATES - 1);
            end else if (state == WAIT && mem_ce_i && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        fire       = 1'b0;
        case (state)
            IDLE: if (mem_ce_i) next_state = WAIT;
            WAIT: begin
                if (!mem_ce_i) begin
                    next_state = IDLE;
                end else if (cnt == '0) begin
                    next_state = DONE;
                    fire       = 1'b1;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The storage access happens on the WAIT->DONE edge, so results are visible in DONE.
    assign lane_we    = (fire && cap_we) ? cap_sel : '0;
    assign re         = fire && !cap_we;
    assign stallreq_o = mem_ce_i && (state != DONE);
    assign ready_o    = (state == DONE);

    data_ram_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (lane_we),
        .re    (re),
        .addr  (cap_addr),
        .wdata (cap_data),
        .rdata (mem_data_o)
    );

endmodule

// File: tb/tb_data_ram_resp.sv
// Self-checking bench for data_ram_resp: directed scenarios plus randomized
// accesses against a word-array reference model.
module tb_data_ram_resp;

    localparam int ADDR_W = 10;
    localparam int WS     = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_ce_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic [3:0]  mem_sel_i = '0;
    logic [31:0] mem_data_i = '0;
    logic [31:0] mem_data_o;
    logic        stallreq_o;
    logic        ready_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_mem [DEPTH];
    bit          model_valid [DEPTH];
    logic [31:0] model_dout = '0;

    data_ram_resp #(
        .ADDR_W      (ADDR_W),
        .WAIT_STATES (WS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_ce_i   (mem_ce_i),
        .mem_we_i   (mem_we_i),
        .mem_addr_i (mem_addr_i),
        .mem_sel_i  (mem_sel_i),
        .mem_data_i (mem_data_i),
        .mem_data_o (mem_data_o),
        .stallreq_o (stallreq_o),
        .ready_o    (ready_o)
    );

    always #5 clk = ~clk;

    function automatic int widx(input logic [31:0] addr);
        return int'(addr[ADDR_W+1:2]);
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [3:0] sel,
                                        input logic [31:0] data);
        logic [31:0] w;
        w = model_mem[widx(addr)];
        for (int l = 0; l < 4; l++) begin
            if (sel[l]) w[l*8 +: 8] = data[l*8 +: 8];
        end
        model_mem[widx(addr)] = w;
    endfunction

    // Drives one CPU access (held stable while stalled) and reports what was seen.
    // drop_at >= 0 releases mem_ce_i in that cycle of the access.
    task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] data, input int drop_at,
                          output int stalls, output int readies, output int done_k,
                          output logic [31:0] rdata);
        mem_ce_i   = 1'b1;
        mem_we_i   = we;
        mem_addr_i = addr;
        mem_sel_i  = sel;
        mem_data_i = data;
        stalls  = 0;
        readies = 0;
        done_k  = -1;
        rdata   = 'x;
        for (int k = 0; k < 24; k++) begin
            if (k == drop_at) mem_ce_i = 1'b0;
            #1;
            if (stallreq_o === 1'b1) stalls++;
            if (ready_o === 1'b1) begin
                readies++;
                rdata  = mem_data_o;
                done_k = k;
            end
            @(posedge clk);
            #1;
            if (k == drop_at || done_k >= 0) break;
        end
    endtask

    task automatic go_idle(input int cycles);
        mem_ce_i = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        mem_ce_i = 1'b0;
        #3;
        checks++;
        if (mem_data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected %h", mem_data_o, 32'h0); end
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready_o); end
        checks++;
        if (stallreq_o !== 1'b0) begin errors++; $display("FAIL reset_stall_idle: got %b expected 0", stallreq_o); end
        mem_ce_i = 1'b1;
        #1;
        checks++;
        if (stallreq_o !== 1'b1) begin errors++; $display("FAIL reset_stall_ce: got %b expected 1", stallreq_o); end
        mem_ce_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        go_idle(2);
    endtask

    task automatic test_write_read;
        int s, r, d;
        logic [31:0] q;
        access(1'b1, 32'h0000_0010, 4'b1111, 32'h1234_5678, -1, s, r, d, q);
        model_write(32'h10, 4'b1111, 32'h1234_5678);
        model_valid[widx(32'h10)] = 1'b1;
        checks++;
        if (s != WS + 1 || r != 1 || d != WS + 1) begin
            errors++; $display("FAIL wr_handshake: stalls=%0d ready=%0d done=%0d expected %0d/1/%0d", s, r, d, WS + 1, WS + 1);
        end
        checks++;
        if (q !== 32'h0) begin errors++; $display("FAIL wr_dout_hold: got %h expected %h", q, 32'h0); end
        access(1'b0, 32'h0000_0010, 4'b0000, 32'h0, -1, s, r, d, q);
        checks++;
        if (s != WS + 1 || r != 1 || d != WS + 1) begin
            errors++; $display("FAIL rd_handshake: stalls=%0d ready=%0d done=%0d expected %0d/1/%0d", s, r, d, WS + 1, WS + 1);
        end
        checks++;
        if (q !== 32'h1234_5678) begin errors++; $display("FAIL rd_data: got %h expected %h", q, 32'h1234_5678); end
        model_dout = q;
        go_idle(1);
    endtask

    task automatic test_byte_lanes;
        int s, r, d;
        logic [31:0] q;
        access(1'b1, 32'h0000_0010, 4'b1000, 32'hAABB_CCDD, -1, s, r, d, q);
        model_write(32'h10, 4'b1000, 32'hAABB_CCDD);
        access(1'b0, 32'h0000_0010, 4'b0001, 32'h0, -1, s, r, d, q);
        checks++;
        if (q !== 32'hAA34_5678) begin errors++; $display("FAIL lane_write: got %h expected %h", q, 32'hAA34_5678); end
        model_dout = q;
        go_idle(1);
    endtask

    task automatic test_abort;
        int s, r, d;
        logic [31:0] q;
        access(1'b1, 32'h0000_0010, 4'b1111, 32'hFFFF_FFFF, 1, s, r, d, q);
        checks++;
        if (r != 0 || s != 1) begin errors++; $display("FAIL abort_handshake: ready=%0d stalls=%0d expected 0/1", r, s); end
        #1;
        checks++;
        if (ready_o !== 1'b0 || mem_data_o !== model_dout) begin
            errors++; $display("FAIL abort_outputs: ready=%b data=%h expected 0/%h", ready_o, mem_data_o, model_dout);
        end
        access(1'b0, 32'h0000_0010, 4'b1111, 32'h0, -1, s, r, d, q);
        checks++;
        if (q !== 32'hAA34_5678 || d != WS + 1) begin
            errors++; $display("FAIL abort_readback: got %h done=%0d expected %h done=%0d", q, d, 32'hAA34_5678, WS + 1);
        end
        model_dout = q;
        go_idle(1);
    endtask

    task automatic test_reset_mid_access;
        int s, r, d;
        logic [31:0] q;
        mem_ce_i   = 1'b1;
        mem_we_i   = 1'b1;
        mem_addr_i = 32'h10;
        mem_sel_i  = 4'b1111;
        mem_data_i = 32'h1111_1111;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (mem_data_o !== 32'h0 || ready_o !== 1'b0 || stallreq_o !== 1'b1) begin
            errors++; $display("FAIL midreset_outputs: data=%h ready=%b stall=%b expected 0/0/1", mem_data_o, ready_o, stallreq_o);
        end
        mem_ce_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_dout = '0;
        go_idle(3);
        checks++;
        if (mem_data_o !== 32'h0) begin errors++; $display("FAIL midreset_hold: got %h expected %h", mem_data_o, 32'h0); end
        access(1'b0, 32'h10, 4'b1111, 32'h0, -1, s, r, d, q);
        checks++;
        if (q !== 32'hAA34_5678) begin errors++; $display("FAIL midreset_word: got %h expected %h", q, 32'hAA34_5678); end
        model_dout = q;
        go_idle(1);
    endtask

    task automatic test_back_to_back;
        int s1, r1, d1, s2, r2, d2;
        logic [31:0] q1, q2;
        access(1'b0, 32'h0000_0010, 4'b1111, 32'h0, -1, s1, r1, d1, q1);
        access(1'b0, 32'h0000_4010, 4'b1111, 32'h0, -1, s2, r2, d2, q2);
        checks++;
        if (q1 !== 32'hAA34_5678 || q2 !== 32'hAA34_5678) begin
            errors++; $display("FAIL b2b_alias: got %h/%h expected %h", q1, q2, 32'hAA34_5678);
        end
        checks++;
        if (d2 != WS + 1 || s2 != WS + 1 || r2 != 1) begin
            errors++; $display("FAIL b2b_nogap: done=%0d stalls=%0d ready=%0d expected %0d/%0d/1", d2, s2, r2, WS + 1, WS + 1);
        end
        model_dout = q2;
        go_idle(1);
    endtask

    task automatic test_sel_zero;
        int s, r, d;
        logic [31:0] q;
        access(1'b1, 32'h0000_0010, 4'b0000, 32'h5555_5555, -1, s, r, d, q);
        checks++;
        if (r != 1) begin errors++; $display("FAIL selzero_ready: got %0d pulses expected 1", r); end
        access(1'b0, 32'h0000_0010, 4'b1111, 32'h0, -1, s, r, d, q);
        checks++;
        if (q !== 32'hAA34_5678) begin errors++; $display("FAIL selzero_data: got %h expected %h", q, 32'hAA34_5678); end
        model_dout = q;
        go_idle(1);
    endtask

    task automatic test_random;
        int idx [8];
        int s, r, d, drop;
        logic [31:0] addr, data, q;
        logic [3:0]  sel;
        logic        we;
        for (int i = 0; i < 8; i++) begin
            idx[i] = int'($urandom_range(0, DEPTH - 1));
            addr = $urandom();
            addr[ADDR_W+1:2] = ADDR_W'(idx[i]);
            data = $urandom();
            access(1'b1, addr, 4'b1111, data, -1, s, r, d, q);
            model_write(addr, 4'b1111, data);
            model_valid[idx[i]] = 1'b1;
        end
        for (int n = 0; n < 60; n++) begin
            addr = $urandom();
            addr[ADDR_W+1:2] = ADDR_W'(idx[$urandom_range(0, 7)]);
            we   = 1'($urandom_range(0, 1));
            sel  = 4'($urandom());
            data = $urandom();
            drop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, WS)) : -1;
            access(we, addr, sel, data, drop, s, r, d, q);
            if (drop >= 0) begin
                checks++;
                if (r != 0 || s != drop) begin
                    errors++; $display("FAIL rand_abort[%0d]: ready=%0d stalls=%0d expected 0/%0d", n, r, s, drop);
                end
            end else begin
                if (we) model_write(addr, sel, data);
                else    model_dout = model_mem[widx(addr)];
                checks++;
                if (r != 1 || s != WS + 1 || q !== model_dout) begin
                    errors++; $display("FAIL rand_access[%0d]: we=%b addr=%h ready=%0d stalls=%0d data=%h expected 1/%0d/%h",
                                       n, we, addr, r, s, q, WS + 1, model_dout);
                end
            end
            if ($urandom_range(0, 1) == 0) go_idle(int'($urandom_range(1, 3)));
        end
        go_idle(2);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_abort();
        test_reset_mid_access();
        test_back_to_back();
        test_sel_zero();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
